// File: rtl/rs232_cmd_responder.sv
// Host command responder on the RS232 byte side: decodes read/write frames, performs one 16-bit
// memory access and answers through the tx handshake. Define RSP_CHECKSUM_EN for XOR-checksummed frames.
module rs232_cmd_responder #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rxData,
   input  logic                  rxReady,
   output logic [7:0]            txData,
   output logic                  txStart,
   input  logic                  txBusy,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [15:0]           memDataOut,
   input  logic [15:0]           memDataIn,
   output logic                  memWE,
   output logic                  memRE,
   input  logic                  memReady,
   output logic                  busy
);
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    OP_WRITE = 8'h57;
   localparam logic [7:0]    OP_READ  = 8'h52;
   localparam logic [7:0]    ACK      = 8'h06;
   localparam logic [7:0]    NAK      = 8'h15;

`ifdef RSP_CHECKSUM_EN
   localparam logic [1:0] CNT_ONE = 2'd2;
   localparam logic [1:0] CNT_TWO = 2'd3;
   typedef enum logic [3:0] {
      IDLE, GET_ADDR_H, GET_ADDR_L, GET_DATA_H, GET_DATA_L, GET_CSUM, MEM, SEND, SEND_WAIT
   } state_t;
`else
   localparam logic [1:0] CNT_ONE = 2'd1;
   localparam logic [1:0] CNT_TWO = 2'd2;
   typedef enum logic [3:0] {
      IDLE, GET_ADDR_H, GET_ADDR_L, GET_DATA_H, GET_DATA_L, MEM, SEND, SEND_WAIT
   } state_t;
`endif

   state_t        state;
   logic          is_write;
   logic [7:0]    addr_h, addr_l, data_h, data_l;
   logic [7:0]    rsp0, rsp1, rsp2;
   logic [1:0]    rsp_cnt, rsp_idx;
   logic [TW-1:0] tcnt;
   logic          skip;
   logic          in_get;
   logic          op_known;
`ifdef RSP_CHECKSUM_EN
   logic [7:0]    csum;
   logic          known;
`endif

   function automatic logic [7:0] rsp_sel(input logic [1:0] idx, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2);
      case (idx)
         2'd0:    return b0;
         2'd1:    return b1;
         default: return b2;
      endcase
   endfunction

   assign busy       = (state != IDLE);
   assign memAddr    = ADDR_WIDTH'({addr_h, addr_l});
   assign memDataOut = {data_h, data_l};
   assign op_known   = (rxData == OP_WRITE) || (rxData == OP_READ);

   always_comb begin
      in_get = 1'b0;
      case (state)
         GET_ADDR_H, GET_ADDR_L, GET_DATA_H, GET_DATA_L: in_get = 1'b1;
`ifdef RSP_CHECKSUM_EN
         GET_CSUM: in_get = 1'b1;
`endif
         default: in_get = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         txData   <= '0;
         txStart  <= 1'b0;
         memWE    <= 1'b0;
         memRE    <= 1'b0;
         is_write <= 1'b0;
         addr_h   <= '0;
         addr_l   <= '0;
         data_h   <= '0;
         data_l   <= '0;
         rsp0     <= '0;
         rsp1     <= '0;
         rsp2     <= '0;
         rsp_cnt  <= '0;
         rsp_idx  <= '0;
         tcnt     <= '0;
         skip     <= 1'b0;
`ifdef RSP_CHECKSUM_EN
         csum     <= '0;
         known    <= 1'b0;
`endif
      end else begin
         txStart <= 1'b0;
         // An abandoned frame drops back to IDLE without any response
         if (in_get && !rxReady) begin
            if (tcnt == TLAST) state <= IDLE;
            else               tcnt  <= tcnt + TW'(1);
         end
         case (state)
            IDLE: if (rxReady) begin
               tcnt     <= '0;
               rsp_idx  <= '0;
               is_write <= (rxData == OP_WRITE);
`ifdef RSP_CHECKSUM_EN
               csum  <= rxData;
               known <= op_known;
               state <= op_known ? GET_ADDR_H : GET_CSUM;
`else
               if (op_known) begin
                  state <= GET_ADDR_H;
               end else begin
                  rsp0    <= NAK;
                  rsp1    <= NAK;
                  rsp_cnt <= CNT_ONE;
                  state   <= SEND;
               end
`endif
            end
            GET_ADDR_H: if (rxReady) begin
               addr_h <= rxData;
               tcnt   <= '0;
`ifdef RSP_CHECKSUM_EN
               csum   <= csum ^ rxData;
`endif
               state  <= GET_ADDR_L;
            end
            GET_ADDR_L: if (rxReady) begin
               addr_l <= rxData;
               tcnt   <= '0;
`ifdef RSP_CHECKSUM_EN
               csum   <= csum ^ rxData;
               state  <= is_write ? GET_DATA_H : GET_CSUM;
`else
               if (is_write) begin
                  state <= GET_DATA_H;
               end else begin
                  memRE <= 1'b1;
                  state <= MEM;
               end
`endif
            end
            GET_DATA_H: if (rxReady) begin
               data_h <= rxData;
               tcnt   <= '0;
`ifdef RSP_CHECKSUM_EN
               csum   <= csum ^ rxData;
`endif
               state  <= GET_DATA_L;
            end
            GET_DATA_L: if (rxReady) begin
               data_l <= rxData;
               tcnt   <= '0;
`ifdef RSP_CHECKSUM_EN
               csum   <= csum ^ rxData;
               state  <= GET_CSUM;
`else
               memWE  <= 1'b1;
               state  <= MEM;
`endif
            end
`ifdef RSP_CHECKSUM_EN
            GET_CSUM: if (rxReady) begin
               tcnt <= '0;
               if (known && (rxData == csum)) begin
                  memWE <= is_write;
                  memRE <= !is_write;
                  state <= MEM;
               end else begin
                  rsp0    <= NAK;
                  rsp1    <= NAK;
                  rsp_cnt <= CNT_ONE;
                  state   <= SEND;
               end
            end
`endif
            MEM: if (memReady) begin
               memWE <= 1'b0;
               memRE <= 1'b0;
               if (is_write) begin
                  rsp0    <= ACK;
                  rsp1    <= ACK;
                  rsp_cnt <= CNT_ONE;
               end else begin
                  rsp0    <= memDataIn[15:8];
                  rsp1    <= memDataIn[7:0];
                  rsp2    <= memDataIn[15:8] ^ memDataIn[7:0];
                  rsp_cnt <= CNT_TWO;
               end
               state <= SEND;
            end
            SEND: if (!txBusy) begin
               txData  <= rsp_sel(rsp_idx, rsp0, rsp1, rsp2);
               txStart <= 1'b1;
               skip    <= 1'b1;
               state   <= SEND_WAIT;
            end
            // txBusy may only rise one cycle after txStart, so the first cycle is ignored
            SEND_WAIT: begin
               if (skip) begin
                  skip <= 1'b0;
               end else if (!txBusy) begin
                  if ((rsp_idx + 2'd1) < rsp_cnt) begin
                     rsp_idx <= rsp_idx + 2'd1;
                     state   <= SEND;
                  end else begin
                     rsp_idx <= '0;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rs232_cmd_responder.sv
// Randomized bench for rs232_cmd_responder against a frame-level reference model.
module tb_rs232_cmd_responder;
   localparam int AW = 16;
   localparam int TO = 60;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rxData;
   logic          rxReady;
   logic [7:0]    txData;
   logic          txStart;
   logic          txBusy;
   logic [AW-1:0] memAddr;
   logic [15:0]   memDataOut;
   logic [15:0]   memDataIn;
   logic          memWE;
   logic          memRE;
   logic          memReady;
   logic          busy;

   always #5 clk = ~clk;

   rs232_cmd_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rxData(rxData), .rxReady(rxReady),
      .txData(txData), .txStart(txStart), .txBusy(txBusy),
      .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
      .memWE(memWE), .memRE(memRE), .memReady(memReady), .busy(busy)
   );

   int tests = 0;
   int fails = 0;
   logic [7:0]  exp_tx[$];
   logic [32:0] exp_op[$];
   logic [15:0] ram[logic [15:0]];
   logic [15:0] shadow[logic [15:0]];
   int mem_lat = -1;

   function automatic logic [15:0] dflt(input logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   function automatic bq_t with_cs(input bq_t fr);
`ifdef RSP_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      foreach (fr[i]) x ^= fr[i];
      fr.push_back(x);
`endif
      return fr;
   endfunction

   task automatic push_rsp(input logic [7:0] b0, input logic [7:0] b1, input int n);
      exp_tx.push_back(b0);
      if (n == 2) exp_tx.push_back(b1);
`ifdef RSP_CHECKSUM_EN
      exp_tx.push_back((n == 2) ? (b0 ^ b1) : b0);
`endif
   endtask

   // Reference: what a complete frame must produce, from the command rules alone
   task automatic model_frame(input bq_t fr);
      int n = fr.size();
      bit ok = 1'b1;
      logic [15:0] a, d;
`ifdef RSP_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int i = 0; i < n - 1; i++) x ^= fr[i];
      ok = (x == fr[n-1]);
      n = n - 1;
`endif
      if (ok && fr[0] == 8'h57 && n == 5) begin
         a = {fr[1], fr[2]};
         d = {fr[3], fr[4]};
         exp_op.push_back({1'b1, a, d});
         shadow[a] = d;
         push_rsp(8'h06, 8'h00, 1);
      end else if (ok && fr[0] == 8'h52 && n == 3) begin
         a = {fr[1], fr[2]};
         d = shadow.exists(a) ? shadow[a] : dflt(a);
         exp_op.push_back({1'b0, a, 16'h0000});
         push_rsp(d[15:8], d[7:0], 2);
      end else begin
         push_rsp(8'h15, 8'h00, 1);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(posedge clk);
      #1;
      rxData  = b;
      rxReady = 1'b1;
      @(posedge clk);
      #1;
      rxReady = 1'b0;
      rxData  = 8'($urandom);
   endtask

   task automatic send_frame(input bq_t fr, input int gapmax);
      foreach (fr[i]) send_byte(fr[i], (i == 0) ? 0 : int'($urandom_range(0, gapmax)));
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         if (!busy && !txBusy && exp_tx.size() == 0 && exp_op.size() == 0) done = 1'b1;
      end
      chk({name, "_complete"}, 32'(done), 32'd1);
      if (!done) begin
         exp_tx.delete();
         exp_op.delete();
      end
   endtask

   task automatic do_frame(input bq_t fr, input string name);
      model_frame(fr);
      send_frame(fr, 4);
      wait_idle(name);
   endtask

   // Transmitter: busy rises one cycle after txStart and lasts a random time
   initial begin
      txBusy = 1'b0;
      forever begin
         @(negedge clk);
         if (txStart) begin
            @(posedge clk);
            #1 txBusy = 1'b1;
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1 txBusy = 1'b0;
         end
      end
   end

   // Memory: random or fixed latency, spurious memReady when nothing is requested
   initial begin
      int  lat = 0;
      bit  act = 1'b0;
      memReady  = 1'b0;
      memDataIn = 16'h0000;
      forever begin
         @(negedge clk);
         if (memWE || memRE) begin
            if (!act) begin
               act = 1'b1;
               lat = (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
            end
            if (lat == 0) begin
               memReady = 1'b1;
               if (memRE) memDataIn = ram.exists(memAddr) ? ram[memAddr] : dflt(memAddr);
               else       ram[memAddr] = memDataOut;
            end else begin
               lat--;
               memReady = 1'b0;
            end
         end else begin
            act       = 1'b0;
            memReady  = ($urandom_range(0, 7) == 0);
            memDataIn = 16'($urandom);
         end
      end
   end

   // Compare process: every txStart and every new memory request against the model queues
   logic        prev_start = 1'b0;
   logic        prev_req   = 1'b0;
   logic [15:0] req_addr   = 16'h0000;
   logic [32:0] mon_e;
   always @(negedge clk) begin
      if (txStart) begin
         chk("tx_busy_at_start", 32'(txBusy), 32'd0);
         chk("tx_pulse_width", 32'(prev_start), 32'd0);
         if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got byte %02h, expected no transmission", txData);
         end else begin
            chk("tx_byte", 32'(txData), 32'(exp_tx.pop_front()));
         end
      end
      if ((memWE || memRE) && !prev_req) begin
         if (exp_op.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mem_unexpected: got we=%0b re=%0b addr=%04h, expected no access",
                     memWE, memRE, memAddr);
         end else begin
            mon_e = exp_op.pop_front();
            chk("mem_we_re", {30'd0, memWE, memRE}, {30'd0, mon_e[32], ~mon_e[32]});
            chk("mem_addr", 32'(memAddr), 32'(mon_e[31:16]));
            if (mon_e[32]) chk("mem_wdata", 32'(memDataOut), 32'(mon_e[15:0]));
         end
         req_addr = memAddr;
      end else if ((memWE || memRE) && memAddr !== req_addr) begin
         chk("mem_addr_stable", 32'(memAddr), 32'(req_addr));
      end
      prev_start = txStart;
      prev_req   = memWE || memRE;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got %0d tests", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t fr;
      bit  seen;
      logic [15:0] a, d;
      logic [7:0]  op;
      rst     = 1'b1;
      rxReady = 1'b0;
      rxData  = 8'h00;
      ram[16'h0010]    = 16'h1234;
      shadow[16'h0010] = 16'h1234;
      repeat (2) @(negedge clk);
      chk("rst_txData", 32'(txData), 32'd0);
      chk("rst_txStart", 32'(txStart), 32'd0);
      chk("rst_memWE", 32'(memWE), 32'd0);
      chk("rst_memRE", 32'(memRE), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_memAddr", 32'(memAddr), 32'd0);
      chk("rst_memDataOut", 32'(memDataOut), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Read from preloaded memory
      fr = with_cs('{8'h52, 8'h00, 8'h10});
      model_frame(fr);
      chk("model_rd_hi", 32'(exp_tx[0]), 32'h12);
      chk("model_rd_lo", 32'(exp_tx[1]), 32'h34);
      send_frame(fr, 3);
      wait_idle("read_1234");

`ifdef RSP_CHECKSUM_EN
      fr = '{8'h52, 8'h00, 8'h10, 8'h42};
      model_frame(fr);
      chk("model_cs_byte", 32'(exp_tx[2]), 32'h26);
      send_frame(fr, 3);
      wait_idle("read_cs_ok");
      fr = '{8'h52, 8'h00, 8'h10, 8'h00};
      model_frame(fr);
      chk("model_cs_nak0", 32'(exp_tx[0]), 32'h15);
      chk("model_cs_nak1", 32'(exp_tx[1]), 32'h15);
      send_frame(fr, 3);
      wait_idle("read_cs_bad");
`endif

      // Write with three-cycle memory latency, then read it back
      mem_lat = 3;
      fr = with_cs('{8'h57, 8'h00, 8'h10, 8'hBE, 8'hEF});
      model_frame(fr);
      chk("model_wr_op", exp_op[0][31:0], 32'h0010BEEF);
      chk("model_wr_ack", 32'(exp_tx[0]), 32'h06);
      send_frame(fr, 3);
      wait_idle("write_beef");
      mem_lat = -1;
      fr = with_cs('{8'h52, 8'h00, 8'h10});
      model_frame(fr);
      chk("model_rd_back", 32'(exp_tx[0]), 32'hBE);
      send_frame(fr, 3);
      wait_idle("read_beef");

      // Unknown opcode
      fr = with_cs('{8'h41});
      model_frame(fr);
      chk("model_nak", 32'(exp_tx[0]), 32'h15);
      send_frame(fr, 0);
      wait_idle("unknown_op");

      // Abandoned frame: silent return to IDLE
      send_frame('{8'h57, 8'h00}, 2);
      repeat (5) @(negedge clk);
      chk("timeout_busy_mid", 32'(busy), 32'd1);
      repeat (TO + 5) @(negedge clk);
      chk("timeout_busy_after", 32'(busy), 32'd0);

      // Gaps just under the limit keep the frame alive
      fr = with_cs('{8'h52, 8'h00, 8'h42});
      model_frame(fr);
      foreach (fr[i]) send_byte(fr[i], (i == 0) ? 0 : TO - 3);
      wait_idle("near_timeout");

      // Bytes arriving while responding are dropped
      fr = with_cs('{8'h52, 8'h00, 8'h10});
      model_frame(fr);
      send_frame(fr, 2);
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(negedge clk);
         if (txStart) seen = 1'b1;
      end
      chk("drop_saw_start", 32'(seen), 32'd1);
      send_byte(8'h41, 0);
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (txBusy) seen = 1'b1;
      end
      send_byte(8'h57, 0);
      wait_idle("drop_during_send");
      do_frame(with_cs('{8'h41}), "after_drop");

      // Reset while a read request is pending
      mem_lat = 20;
      fr = with_cs('{8'h52, 8'h00, 8'h20});
      model_frame(fr);
      send_frame(fr, 2);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (memRE) seen = 1'b1;
      end
      chk("rst_mem_saw_re", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mem_memRE", 32'(memRE), 32'd0);
      chk("rst_mem_busy", 32'(busy), 32'd0);
      chk("rst_mem_memAddr", 32'(memAddr), 32'd0);
      exp_tx.delete();
      exp_op.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_lat = -1;

      // Reset while the transmitter is busy
      fr = with_cs('{8'h52, 8'h00, 8'h30});
      model_frame(fr);
      send_frame(fr, 2);
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (txBusy) seen = 1'b1;
      end
      chk("rst_tx_saw_busy", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_tx_txStart", 32'(txStart), 32'd0);
      chk("rst_tx_txData", 32'(txData), 32'd0);
      chk("rst_tx_busy", 32'(busy), 32'd0);
      exp_tx.delete();
      exp_op.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      do_frame(with_cs('{8'h52, 8'h00, 8'h30}), "read_after_rst");

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0: a = 16'h0010;
            1: a = 16'hFFFF;
            2: a = 16'h00FF;
            default: a = {12'h000, 4'($urandom)};
         endcase
         d = 16'($urandom);
         case ($urandom_range(0, 3))
            0: fr = with_cs('{8'h52, a[15:8], a[7:0]});
            1: fr = with_cs('{8'h57, a[15:8], a[7:0], d[15:8], d[7:0]});
            2: begin
               op = 8'($urandom);
               while (op == 8'h52 || op == 8'h57) op = 8'($urandom);
               fr = with_cs('{op});
            end
            default: begin
               fr = with_cs('{8'h57, a[15:8], a[7:0], d[15:8], d[7:0]});
`ifdef RSP_CHECKSUM_EN
               fr[fr.size()-1] = ~fr[fr.size()-1];
`endif
            end
         endcase
         do_frame(fr, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
